// File: rtl/adaptive_filter_pkg.sv
// Shared definitions for the adaptive filter datapath.
//   acc_state_t     : tap accumulator control states (encoding is fixed and
//                     shared with other blocks of the filter).
//   DEF_PROD_WIDTH  : default width of the unsigned 8x8 multiplier product.
//   DEF_NUM_TAPS    : default number of products summed per output sample.
package adaptive_filter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no taps held
        ACCUM = 2'd1,   // 1..NUM_TAPS-1 taps held
        HOLD  = 2'd2    // completed sum presented downstream
    } acc_state_t;

    localparam int unsigned DEF_PROD_WIDTH = 16;
    localparam int unsigned DEF_NUM_TAPS   = 8;

endpackage

// File: rtl/tap_product_accumulator_if.sv
// Product-in / sum-out handshake bundle of the tap product accumulator.
//   prod_valid/prod_data/prod_last/prod_ready : upstream product stream
//   out_valid/out_data/out_ready              : downstream sum stream
//   frame_err                                 : prod_last/tap-count mismatch pulse
// Modports:
//   master : the environment side (drives products and out_ready)
//   slave  : the accumulator side
interface tap_product_accumulator_if
    import adaptive_filter_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_PROD_WIDTH + $clog2(DEF_NUM_TAPS)
) ();

    logic                  prod_valid;
    logic [PROD_WIDTH-1:0] prod_data;
    logic                  prod_last;
    logic                  prod_ready;
    logic                  out_valid;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  out_ready;
    logic                  frame_err;

    modport master (
        output prod_valid, prod_data, prod_last, out_ready,
        input  prod_ready, out_valid, out_data, frame_err
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, out_ready,
        output prod_ready, out_valid, out_data, frame_err
    );

endinterface

// File: rtl/manchester_carry_chain_adder.sv
// Unsigned WIDTH-bit adder built from a generate/propagate carry chain.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, truncated to WIDTH bits (callers size WIDTH so the
//          carry out of the top bit is never needed)
module manchester_carry_chain_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             carry;

    // Carry ripples along the chain: each stage either generates a carry,
    // passes the incoming one through (propagate), or kills it.
    always_comb begin
        gen   = a & b;
        prop  = a ^ b;
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = prop[i] ^ carry;
            carry  = gen[i] | (prop[i] & carry);
        end
    end

endmodule

// File: rtl/tap_product_accumulator.sv
// Sums NUM_TAPS unsigned tap products into one output sample.
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : slave side of tap_product_accumulator_if
//           prod_valid/prod_data/prod_last in, prod_ready out
//           out_valid/out_data out, out_ready in
//           frame_err out (one-cycle pulse on prod_last/tap-count mismatch)
// The tap count alone decides where a sample ends; prod_last is only
// cross-checked and reported through frame_err.
module tap_product_accumulator
    import adaptive_filter_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS,
    parameter int unsigned ACC_WIDTH  = PROD_WIDTH + $clog2(NUM_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tap_product_accumulator_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS);

    generate
        if (NUM_TAPS < 2 || NUM_TAPS > 256) begin : g_bad_taps
            $error("tap_product_accumulator: NUM_TAPS must be within 2..256");
        end
        if (ACC_WIDTH < PROD_WIDTH + $clog2(NUM_TAPS)) begin : g_bad_acc
            $error("tap_product_accumulator: ACC_WIDTH too narrow for NUM_TAPS products");
        end
    endgenerate

    acc_state_t           state;
    acc_state_t           state_nxt;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0]     tap_cnt;
    logic [CNT_W-1:0]     tap_num;
    logic                 frame_err_q;

    logic                 prod_ready;
    logic                 out_valid;
    logic                 prod_xfer;
    logic                 out_xfer;
    logic                 start_tap;
    logic                 final_tap;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (prod_xfer) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (prod_xfer && final_tap) state_nxt = HOLD;
            end
            HOLD: begin
                // A product can only be taken in HOLD together with the
                // pending sum, and it opens the next sample.
                if (out_xfer) state_nxt = prod_xfer ? ACCUM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        prod_ready = 1'b1;
        out_valid  = 1'b0;
        if (state == HOLD) begin
            prod_ready = bus.out_ready;
            out_valid  = 1'b1;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data_q;
    assign bus.frame_err  = frame_err_q;

    // ---------------- datapath ----------------
    assign prod_xfer = bus.prod_valid & prod_ready;
    assign out_xfer  = out_valid & bus.out_ready;

    // Any product accepted outside ACCUM is tap 1 of a new sample; tap 1 is
    // never the final tap because NUM_TAPS >= 2.
    assign start_tap = (state != ACCUM);
    assign tap_num   = start_tap ? CNT_W'(1) : tap_cnt + 1'b1;
    assign final_tap = !start_tap && (tap_num == LAST_TAP);
    assign prod_ext  = ACC_WIDTH'(bus.prod_data);

    manchester_carry_chain_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .a   (acc),
        .b   (prod_ext),
        .cin (1'b0),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            tap_cnt     <= '0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= prod_xfer && (bus.prod_last != final_tap);
            if (prod_xfer) begin
                if (start_tap) begin
                    acc     <= prod_ext;
                    tap_cnt <= CNT_W'(1);
                end else if (final_tap) begin
                    out_data_q <= sum;
                    acc        <= '0;
                    tap_cnt    <= '0;
                end else begin
                    acc     <= sum;
                    tap_cnt <= tap_num;
                end
            end
        end
    end

endmodule

// File: doc/tap_product_accumulator.md
TAP_PRODUCT_ACCUMULATOR -- requirements
Module: tap_product_accumulator

Interface
REQ-001 Parameter PROD_WIDTH, default 16, width of the unsigned products from the 8x8 multiplier.
REQ-002 Parameter NUM_TAPS, default 8, products summed per output sample (legal range 2..256).
REQ-003 Parameter ACC_WIDTH, default PROD_WIDTH+$clog2(NUM_TAPS), accumulator and output width; SHALL be at least that value (elaboration error otherwise).
REQ-004 One clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 prod_valid  input  1  upstream product valid.
REQ-008 prod_data  input  PROD_WIDTH  unsigned tap product.
REQ-009 prod_last  input  1  upstream marks final tap of a sample.
REQ-010 prod_ready  output  1  block accepts a product this cycle.
REQ-011 out_valid  output  1  accumulated sum available.
REQ-012 out_data  output  ACC_WIDTH  sum of NUM_TAPS products.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 frame_err  output  1  one-cycle pulse on prod_last/tap-count mismatch.

Function
REQ-015 Transfer SHALL occur on a rising edge where prod_valid and prod_ready are both 1; out transfer where out_valid and out_ready are both 1.
REQ-016 States: IDLE (no taps held), ACCUM (1..NUM_TAPS-1 taps held), HOLD (sum presented).
REQ-017 prod_ready SHALL be 1 in IDLE and ACCUM, and in HOLD equal out_ready (combinational).
REQ-018 First accepted product of a sample SHALL load acc = zero-extended prod_data and set tap_cnt = 1; IDLE->ACCUM.
REQ-019 Each further accepted product SHALL do acc = acc + prod_data and tap_cnt = tap_cnt + 1; no wrap or saturation is needed as ACC_WIDTH covers the maximum sum.
REQ-020 Acceptance of tap NUM_TAPS SHALL register the final sum into out_data, set out_valid = 1 on the next cycle, clear tap_cnt; ACCUM->HOLD. Latency: last product accepted at edge N -> out_valid high after edge N.
REQ-021 In HOLD, out_data and out_valid SHALL remain stable until out transfer; no transfer leaves HOLD unchanged.
REQ-022 In HOLD, out transfer with no product transfer: out_valid = 0, HOLD->IDLE.
REQ-023 In HOLD, simultaneous out transfer and product transfer: that product starts the next sample (load as REQ-018), HOLD->ACCUM, out_valid = 0; one sample per NUM_TAPS cycles sustained.
REQ-024 frame_err SHALL pulse high for exactly the cycle after a product transfer where prod_last = 1 with tap number < NUM_TAPS, or prod_last = 0 on tap NUM_TAPS; the tap count alone governs sample boundaries (the sample still completes normally).
REQ-025 prod_data SHALL be ignored when prod_valid = 0; out_ready SHALL be ignored when out_valid = 0.

Reset
REQ-026 rst_n low SHALL asynchronously force state = IDLE, acc = 0, tap_cnt = 0, out_valid = 0, out_data = 0, frame_err = 0.
REQ-027 Reset mid-sample or in HOLD SHALL discard partial and pending sums; first transfer after release starts a new sample.
REQ-028 prod_ready SHALL be 1 from the first edge after reset release.

Structure
REQ-029 Shared package adaptive_filter_pkg SHALL hold the state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2), default PROD_WIDTH and NUM_TAPS.
REQ-030 The accumulate addition SHALL use one instance of the existing manchester_carry_chain_adder at ACC_WIDTH, with the product zero-extended; no other sub-module.
REQ-031 No combinational path from prod_* to out_*; the only combinational input-to-output path is out_ready->prod_ready.

Verification (NUM_TAPS=4, PROD_WIDTH=16, ACC_WIDTH=18)
REQ-032 Products 1,2,3,4 back-to-back with last on 4th, out_ready=1 -> out_valid one cycle after 4th transfer, out_data=10, frame_err never high.
REQ-033 Four products of 65025 (255*255) -> out_data=260100, no overflow.
REQ-034 out_ready=0 for 5 cycles after sample 7,7,7,7 -> out_valid and out_data=28 held stable, prod_ready=0 throughout, no product lost when valid held.
REQ-035 Continuous stream of 3 samples with out_ready=1 -> outputs every 4 cycles, HOLD->ACCUM overlap exercised, sums correct.
REQ-036 prod_last on tap 2 of a sample -> frame_err pulses once; sample still closes at tap 4 with correct sum.
REQ-037 rst_n low after 2 taps (5,6), release, then 1,1,1,1 -> out_data=4, out_valid=0 during reset.
